// File: rtl/vec_de_pipe_reg.sv
// Decode-to-execute vector pipeline register with a two-entry skid buffer,
// scalar lane masking and a saturating bubble/stall counter.
module vec_de_pipe_reg #(
   parameter int LANES     = 4,
   parameter int LANE_W    = 32,
   parameter int ALUCTRL_W = 3,
   parameter int RD_W      = 4,
   parameter int IMM_W     = 32,
   parameter int CNT_W     = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    stall,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_regw,
   input  logic                    in_memw,
   input  logic                    in_regmem,
   input  logic                    in_vect,
   input  logic                    in_aluop,
   input  logic [ALUCTRL_W-1:0]    in_aluctrl,
   input  logic [RD_W-1:0]         in_rd,
   input  logic [LANES*LANE_W-1:0] in_a,
   input  logic [LANES*LANE_W-1:0] in_b,
   input  logic [IMM_W-1:0]        in_imm,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_regw,
   output logic                    out_memw,
   output logic                    out_regmem,
   output logic                    out_vect,
   output logic                    out_aluop,
   output logic [ALUCTRL_W-1:0]    out_aluctrl,
   output logic [RD_W-1:0]         out_rd,
   output logic [LANES*LANE_W-1:0] out_a,
   output logic [LANES*LANE_W-1:0] out_b,
   output logic [IMM_W-1:0]        out_imm,
   output logic [CNT_W-1:0]        bubble_cnt
);

   localparam int OP_W = LANES * LANE_W;

   typedef struct packed {
      logic                 regw;
      logic                 memw;
      logic                 regmem;
      logic                 vect;
      logic                 aluop;
      logic [ALUCTRL_W-1:0] aluctrl;
      logic [RD_W-1:0]      rd;
      logic [OP_W-1:0]      a;
      logic [OP_W-1:0]      b;
      logic [IMM_W-1:0]     imm;
   } ent_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   ent_t             m_q;
   ent_t             s_q;
   ent_t             m_nx;
   ent_t             s_nx;
   ent_t             in_ent;
   logic             accept;
   logic             consume;
   logic [CNT_W-1:0] cnt_q;

   // Scalar ops keep only lane 0 so stale upper lanes never reach execute.
   function automatic logic [OP_W-1:0] lane_mask(
      input logic [OP_W-1:0] v,
      input logic            vect
   );
      logic [OP_W-1:0] r;
      r = v;
      if (!vect) begin
         for (int l = 1; l < LANES; l++) begin
            r[l*LANE_W +: LANE_W] = '0;
         end
      end
      return r;
   endfunction

   always_comb begin
      in_ent         = '0;
      in_ent.regw    = in_regw;
      in_ent.memw    = in_memw;
      in_ent.regmem  = in_regmem;
      in_ent.vect    = in_vect;
      in_ent.aluop   = in_aluop;
      in_ent.aluctrl = in_aluctrl;
      in_ent.rd      = in_rd;
      in_ent.a       = lane_mask(in_a, in_vect);
      in_ent.b       = lane_mask(in_b, in_vect);
      in_ent.imm     = in_imm;
   end

   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign accept    = in_valid & in_ready;
   assign consume   = out_valid & out_ready & ~stall;

   always_comb begin
      state_nx = state;
      m_nx     = m_q;
      s_nx     = s_q;
      if (flush) begin
         state_nx = EMPTY;
         m_nx     = '0;
         s_nx     = '0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (accept) begin
                  m_nx     = in_ent;
                  state_nx = ONE;
               end
            end
            ONE: begin
               if (accept && consume) begin
                  m_nx = in_ent;
               end else if (accept) begin
                  s_nx     = in_ent;
                  state_nx = FULL;
               end else if (consume) begin
                  state_nx = EMPTY;
               end
            end
            FULL: begin
               if (consume) begin
                  m_nx     = s_q;
                  s_nx     = '0;
                  state_nx = ONE;
               end
            end
            default: begin
               state_nx = EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= EMPTY;
         m_q   <= '0;
         s_q   <= '0;
      end else begin
         state <= state_nx;
         m_q   <= m_nx;
         s_q   <= s_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if ((!out_valid || stall) && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bubble_cnt  = cnt_q;
   assign out_regw    = m_q.regw;
   assign out_memw    = m_q.memw;
   assign out_regmem  = m_q.regmem;
   assign out_vect    = m_q.vect;
   assign out_aluop   = m_q.aluop;
   assign out_aluctrl = m_q.aluctrl;
   assign out_rd      = m_q.rd;
   assign out_a       = m_q.a;
   assign out_b       = m_q.b;
   assign out_imm     = m_q.imm;

endmodule

// File: tb/tb_vec_de_pipe_reg.sv
// Self-checking bench for vec_de_pipe_reg: FIFO reference model with
// directed scenarios followed by randomized traffic.
module tb_vec_de_pipe_reg;

   localparam int W = 300;

   typedef struct packed {
      logic         regw;
      logic         memw;
      logic         regmem;
      logic         vect;
      logic         aluop;
      logic [2:0]   aluctrl;
      logic [3:0]   rd;
      logic [127:0] a;
      logic [127:0] b;
      logic [31:0]  imm;
   } pkt_t;

   logic         clk = 0;
   logic         rst_n, flush, stall, in_valid, out_ready;
   logic         in_regw, in_memw, in_regmem, in_vect, in_aluop;
   logic [2:0]   in_aluctrl;
   logic [3:0]   in_rd;
   logic [127:0] in_a, in_b;
   logic [31:0]  in_imm;

   logic         in_ready, out_valid;
   logic         out_regw, out_memw, out_regmem, out_vect, out_aluop;
   logic [2:0]   out_aluctrl;
   logic [3:0]   out_rd;
   logic [127:0] out_a, out_b;
   logic [31:0]  out_imm;
   logic [15:0]  bubble_cnt;

   logic         s_in_ready, s_out_valid;
   logic         s_regw, s_memw, s_regmem, s_vect, s_aluop;
   logic [2:0]   s_aluctrl;
   logic [3:0]   s_rd;
   logic [127:0] s_a, s_b;
   logic [31:0]  s_imm;
   logic [3:0]   s_cnt;

   int checks = 0;
   int failures = 0;

   pkt_t q[$];
   int   cnt_m;
   int   cnt_s;
   bit   cleared;

   always #5 clk = ~clk;

   vec_de_pipe_reg dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_regw(in_regw), .in_memw(in_memw), .in_regmem(in_regmem),
      .in_vect(in_vect), .in_aluop(in_aluop), .in_aluctrl(in_aluctrl),
      .in_rd(in_rd), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_regw(out_regw), .out_memw(out_memw), .out_regmem(out_regmem),
      .out_vect(out_vect), .out_aluop(out_aluop),
      .out_aluctrl(out_aluctrl), .out_rd(out_rd),
      .out_a(out_a), .out_b(out_b), .out_imm(out_imm),
      .bubble_cnt(bubble_cnt)
   );

   vec_de_pipe_reg #(.CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
      .in_valid(in_valid), .in_ready(s_in_ready),
      .in_regw(in_regw), .in_memw(in_memw), .in_regmem(in_regmem),
      .in_vect(in_vect), .in_aluop(in_aluop), .in_aluctrl(in_aluctrl),
      .in_rd(in_rd), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
      .out_valid(s_out_valid), .out_ready(out_ready),
      .out_regw(s_regw), .out_memw(s_memw), .out_regmem(s_regmem),
      .out_vect(s_vect), .out_aluop(s_aluop),
      .out_aluctrl(s_aluctrl), .out_rd(s_rd),
      .out_a(s_a), .out_b(s_b), .out_imm(s_imm),
      .bubble_cnt(s_cnt)
   );

   function automatic pkt_t cur_in();
      pkt_t p;
      p = {in_regw, in_memw, in_regmem, in_vect, in_aluop,
           in_aluctrl, in_rd, in_a, in_b, in_imm};
      if (!p.vect) begin
         p.a = {96'd0, p.a[31:0]};
         p.b = {96'd0, p.b[31:0]};
      end
      return p;
   endfunction

   function automatic pkt_t rand_pkt();
      pkt_t p;
      p.regw    = 1'($urandom);
      p.memw    = 1'($urandom);
      p.regmem  = 1'($urandom);
      p.vect    = 1'($urandom);
      p.aluop   = 1'($urandom);
      p.aluctrl = 3'($urandom);
      p.rd      = 4'($urandom);
      p.a       = {$urandom, $urandom, $urandom, $urandom};
      p.b       = {$urandom, $urandom, $urandom, $urandom};
      p.imm     = $urandom;
      return p;
   endfunction

   task automatic drive(input pkt_t p);
      {in_regw, in_memw, in_regmem, in_vect, in_aluop,
       in_aluctrl, in_rd, in_a, in_b, in_imm} = p;
   endtask

   task automatic chk(input string tag, input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      bit rdy;
      bit cons;
      @(posedge clk);
      if (!rst_n) begin
         q.delete();
         cnt_m   = 0;
         cnt_s   = 0;
         cleared = 1;
      end else begin
         if (q.size() == 0 || stall) begin
            if (cnt_m < 65535) cnt_m++;
            if (cnt_s < 15) cnt_s++;
         end
         cleared = 0;
         if (flush) begin
            q.delete();
            cleared = 1;
         end else begin
            rdy  = q.size() < 2;
            cons = q.size() > 0 && out_ready && !stall;
            if (cons) void'(q.pop_front());
            if (in_valid && rdy) q.push_back(cur_in());
         end
      end
      #1;
      chk("out_valid", W'(out_valid), W'(q.size() > 0));
      chk("in_ready", W'(in_ready), W'(q.size() < 2));
      chk("bubble_cnt", W'(bubble_cnt), W'(cnt_m));
      chk("bubble_cnt_sat", W'(s_cnt), W'(cnt_s));
      if (q.size() > 0) begin
         chk("out_bundle", W'({out_regw, out_memw, out_regmem, out_vect,
             out_aluop, out_aluctrl, out_rd, out_a, out_b, out_imm}),
             W'(q[0]));
         chk("out_bundle_sat", W'({s_regw, s_memw, s_regmem, s_vect,
             s_aluop, s_aluctrl, s_rd, s_a, s_b, s_imm}), W'(q[0]));
      end
      if (cleared) begin
         chk("out_zero", W'({out_regw, out_memw, out_regmem, out_vect,
             out_aluop, out_aluctrl, out_rd, out_a, out_b, out_imm}), '0);
      end
   endtask

   initial begin
      pkt_t p;
      rst_n = 0; flush = 0; stall = 0; in_valid = 0; out_ready = 0;
      drive('0);
      cnt_m = 0; cnt_s = 0; cleared = 0;

      // reset, then pass-through of a vector op
      tick(); tick();
      rst_n = 1;
      p = rand_pkt();
      p.vect = 1; p.a = 128'h0000FFFF0000FFFF0000FFFF0000FFFF;
      p.aluctrl = 3'b101; p.rd = 4'h3;
      drive(p); in_valid = 1; out_ready = 1;
      tick();
      chk("pass_a", W'(out_a), W'(128'h0000FFFF0000FFFF0000FFFF0000FFFF));

      // scalar lane masking
      p = rand_pkt();
      p.vect = 0; p.a = 128'h11111111_22222222_33333333_44444444;
      drive(p);
      tick();
      chk("mask_a", W'(out_a), W'(128'h44444444));
      in_valid = 0;
      tick();

      // skid fill: A, B accepted, C held off until space frees
      out_ready = 0; in_valid = 1;
      drive(rand_pkt()); tick();
      drive(rand_pkt()); tick();
      chk("skid_full_ready", W'(in_ready), W'(0));
      drive(rand_pkt()); tick(); tick();
      out_ready = 1;
      tick();
      in_valid = 0;
      repeat (3) tick();

      // fill, stall for three cycles, then flush under stall
      out_ready = 0; in_valid = 1;
      drive(rand_pkt()); tick();
      drive(rand_pkt()); tick();
      out_ready = 1; stall = 1;
      repeat (3) tick();
      flush = 1; drive(rand_pkt());
      tick();
      flush = 0; in_valid = 0; stall = 0;
      chk("flush_ready", W'(in_ready), W'(1));
      repeat (2) tick();

      // reset while full
      out_ready = 0; in_valid = 1;
      drive(rand_pkt()); tick();
      drive(rand_pkt()); tick();
      in_valid = 0; rst_n = 0;
      tick();
      rst_n = 1; out_ready = 1;
      chk("rst_cnt", W'(bubble_cnt), W'(0));
      repeat (3) tick();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive(rand_pkt());
         in_valid  = ($urandom_range(0, 99) < 60);
         out_ready = ($urandom_range(0, 99) < 65);
         stall     = ($urandom_range(0, 99) < 10);
         flush     = ($urandom_range(0, 99) < 3);
         rst_n     = ($urandom_range(0, 99) >= 1);
         tick();
      end

      // idle saturation of the 4-bit counter
      rst_n = 0; flush = 0; stall = 0; in_valid = 0; out_ready = 0;
      tick();
      rst_n = 1;
      repeat (20) tick();
      chk("sat_hold", W'(s_cnt), W'(4'hF));
      chk("idle_cnt", W'(bubble_cnt), W'(20));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
